// File: rtl/dlx_dbg_pkg.sv
// rtl/dlx_dbg_pkg.sv - command, state and halt-cause encodings for the DLX run controller
package dlx_dbg_pkg;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   typedef logic [1:0] run_state_t;
   localparam run_state_t ST_HALTED   = 2'd0;
   localparam run_state_t ST_RUNNING  = 2'd1;
   localparam run_state_t ST_STEPPING = 2'd2;

   localparam logic [1:0] CAUSE_RESET  = 2'b00;
   localparam logic [1:0] CAUSE_BUDGET = 2'b01;
   localparam logic [1:0] CAUSE_HOST   = 2'b10;
   localparam logic [1:0] CAUSE_BREAK  = 2'b11;

   // Host halt outranks a breakpoint, which outranks budget expiry.
   function automatic logic [1:0] pick_cause(input logic host, input logic brk);
      if (host)
         return CAUSE_HOST;
      else if (brk)
         return CAUSE_BREAK;
      else
         return CAUSE_BUDGET;
   endfunction

endpackage

// File: rtl/run_budget_counter.sv
// rtl/run_budget_counter.sv - loadable down-counter of remaining enabled cycles
module run_budget_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             load_unlim,
   input  logic             dec,
   output logic             expire
);

   logic [CNT_W-1:0] remaining;
   logic             unlimited;

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= '0;
         unlimited <= 1'b0;
      end else if (load) begin
         remaining <= load_val;
         unlimited <= load_unlim;
      end else if (dec && !unlimited && remaining != '0) begin
         remaining <= remaining - CNT_W'(1);
      end
   end

   assign expire = dec & ~unlimited & (remaining == CNT_W'(1));

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/step/halt clock-enable sequencer for the DLX CPU
// Optional breakpoint support is built when DLX_BREAKPOINT_EN is defined.
module cpu_run_controller
   import dlx_dbg_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_arg,
   output logic             cpu_en,
   output logic             halted,
   output logic             done,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] cycle_count,
`ifdef DLX_BREAKPOINT_EN
   input  logic [31:0]      bp_addr,
   input  logic             bp_valid,
`endif
   input  logic [31:0]      pc
);

   run_state_t       state;
   logic             en_q;
   logic             accept;
   logic             start_run;
   logic             start_step;
   logic             host_halt;
   logic             expire;
   logic             bp_hit;
   logic [CNT_W-1:0] load_val;

   assign cmd_ready  = (state == ST_HALTED) | (cmd_op == OP_HALT);
   assign accept     = cmd_valid & cmd_ready;
   assign start_run  = accept & (state == ST_HALTED) & (cmd_op == OP_RUN);
   assign start_step = accept & (state == ST_HALTED) & (cmd_op == OP_STEP);
   assign host_halt  = accept & (state != ST_HALTED) & (cmd_op == OP_HALT);
   assign halted     = (state == ST_HALTED);

   // A zero STEP count still advances one cycle; a zero RUN budget means unlimited.
   assign load_val = (start_step && cmd_arg == '0) ? CNT_W'(1) : cmd_arg;

`ifdef DLX_BREAKPOINT_EN
   logic skip_bp;

   assign bp_hit = (state == ST_RUNNING) & bp_valid & (pc == bp_addr) & ~skip_bp;

   // Lets a resumed RUN execute the instruction it stopped on.
   always_ff @(posedge clk) begin
      if (rst)
         skip_bp <= 1'b0;
      else if (start_run)
         skip_bp <= 1'b1;
      else if (cpu_en)
         skip_bp <= 1'b0;
   end
`else
   logic unused_pc;

   assign bp_hit    = 1'b0;
   assign unused_pc = ^pc;
`endif

   assign cpu_en = en_q & ~bp_hit;

   run_budget_counter #(.CNT_W(CNT_W)) u_budget (
      .clk        (clk),
      .rst        (rst),
      .load       (start_run | start_step),
      .load_val   (load_val),
      .load_unlim (start_run & (cmd_arg == '0)),
      .dec        (cpu_en),
      .expire     (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_HALTED;
         en_q        <= 1'b0;
         done        <= 1'b0;
         halt_cause  <= CAUSE_RESET;
         cycle_count <= '0;
      end else begin
         done <= 1'b0;
         if (cpu_en)
            cycle_count <= cycle_count + CNT_W'(1);
         if (state == ST_HALTED) begin
            if (start_run) begin
               state <= ST_RUNNING;
               en_q  <= 1'b1;
            end else if (start_step) begin
               state <= ST_STEPPING;
               en_q  <= 1'b1;
            end
         end else if (host_halt | bp_hit | expire) begin
            state      <= ST_HALTED;
            en_q       <= 1'b0;
            done       <= 1'b1;
            halt_cause <= pick_cause(host_halt, bp_hit);
         end
      end
   end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - self-checking bench for cpu_run_controller
// Breakpoint checks are included when DLX_BREAKPOINT_EN is defined.
module tb_cpu_run_controller;

   localparam logic [1:0] NOP  = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] STEP = 2'b10;
   localparam logic [1:0] HALT = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic        cpu_en;
   logic        halted;
   logic        done;
   logic [1:0]  halt_cause;
   logic [31:0] cycle_count;
   logic [31:0] pc;
   logic [31:0] bp_addr;
   logic        bp_valid;
   logic        pc_load;

   int          total = 0;
   int          bad = 0;
   logic [31:0] model_cc;

   always #5 clk = ~clk;

   // Toy CPU: fetch address advances by one word per enabled cycle.
   always @(posedge clk) begin
      if (pc_load)
         pc <= 32'h30;
      else if (cpu_en)
         pc <= pc + 32'd4;
   end

   cpu_run_controller #(.CNT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_arg     (cmd_arg),
      .cpu_en      (cpu_en),
      .halted      (halted),
      .done        (done),
      .halt_cause  (halt_cause),
      .cycle_count (cycle_count),
`ifdef DLX_BREAKPOINT_EN
      .bp_addr     (bp_addr),
      .bp_valid    (bp_valid),
`endif
      .pc          (pc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      check("ready_when_halted", {31'd0, cmd_ready}, 32'd1);
      tick;
      cmd_valid = 1'b0;
      cmd_op    = NOP;
   endtask

   // Counts enabled cycles until the done pulse; optionally issues HALT on the
   // halt_after-th enabled cycle and probes that RUN stalls while busy.
   task automatic wait_stop(input int halt_after, input bit probe,
                            output int en_cnt, output int done_cnt, output logic first_en);
      en_cnt   = 0;
      done_cnt = 0;
      first_en = cpu_en;
      for (int c = 0; c < 300; c++) begin
         if (done) begin
            done_cnt++;
            break;
         end
         if (cpu_en)
            en_cnt++;
         cmd_valid = 1'b0;
         cmd_op    = NOP;
         if (cpu_en && halt_after != 0 && en_cnt == halt_after) begin
            cmd_valid = 1'b1;
            cmd_op    = HALT;
         end else if (probe && cpu_en && en_cnt == 2) begin
            cmd_valid = 1'b1;
            cmd_op    = RUN;
            #1;
            check("run_stalls_while_busy", {31'd0, cmd_ready}, 32'd0);
         end
         tick;
      end
      cmd_valid = 1'b0;
      cmd_op    = NOP;
   endtask

   task automatic exec(input logic [1:0] op, input logic [31:0] arg, input int halt_after,
                       input bit probe, input string tag);
      int          budget;
      int          exp_en;
      logic [1:0]  exp_cause;
      int          en_cnt;
      int          done_cnt;
      logic        first_en;
      if (op == RUN)
         budget = int'(arg);
      else
         budget = (arg == 32'd0) ? 1 : int'(arg);
      if (halt_after != 0 && (budget == 0 || halt_after <= budget)) begin
         exp_en    = halt_after;
         exp_cause = HALT == HALT ? 2'b10 : 2'b10;
      end else begin
         exp_en    = budget;
         exp_cause = 2'b01;
      end
      issue(op, arg);
      wait_stop(halt_after, probe, en_cnt, done_cnt, first_en);
      model_cc = model_cc + 32'(exp_en);
      check({tag, "_first_en"}, {31'd0, first_en}, 32'd1);
      check({tag, "_en_cycles"}, 32'(en_cnt), 32'(exp_en));
      check({tag, "_done"}, 32'(done_cnt), 32'd1);
      check({tag, "_cause"}, {30'd0, halt_cause}, {30'd0, exp_cause});
      check({tag, "_cycle_count"}, cycle_count, model_cc);
      check({tag, "_halted"}, {31'd0, halted}, 32'd1);
      tick;
      check({tag, "_done_single"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int          en_cnt;
      int          done_cnt;
      logic        first_en;
      logic [1:0]  rop;
      logic [31:0] rarg;
      int          rhalt;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = NOP;
      cmd_arg   = 32'd0;
      bp_addr   = 32'd0;
      bp_valid  = 1'b0;
      pc_load   = 1'b1;
      model_cc  = 32'd0;
      repeat (3) tick;
      rst     = 1'b0;
      pc_load = 1'b0;

      repeat (10) tick;
      check("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
      check("reset_halted", {31'd0, halted}, 32'd1);
      check("reset_cycle_count", cycle_count, 32'd0);
      check("reset_cause", {30'd0, halt_cause}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);

      exec(RUN, 32'd5, 0, 1'b1, "run5");
      exec(STEP, 32'd0, 0, 1'b0, "step0");
      exec(STEP, 32'd3, 0, 1'b0, "step3");
      exec(RUN, 32'd0, 7, 1'b1, "run_unlim_host");
      exec(RUN, 32'd3, 3, 1'b0, "host_on_expiry");

      // HALT and NOP while halted are accepted and do nothing.
      cmd_valid = 1'b1;
      cmd_op    = HALT;
      #1;
      check("halt_idle_ready", {31'd0, cmd_ready}, 32'd1);
      tick;
      cmd_op = NOP;
      tick;
      cmd_valid = 1'b0;
      check("idle_cmd_no_done", {31'd0, done}, 32'd0);
      check("idle_cmd_halted", {31'd0, halted}, 32'd1);
      check("idle_cmd_cause_kept", {30'd0, halt_cause}, 32'd2);
      check("idle_cmd_count", cycle_count, model_cc);

      for (int i = 0; i < 12; i++) begin
         rop   = $urandom_range(0, 1) ? RUN : STEP;
         rarg  = 32'($urandom_range(0, 6));
         rhalt = $urandom_range(0, 7);
         if (rop == RUN && rarg == 32'd0 && rhalt == 0)
            rhalt = $urandom_range(1, 7);
         exec(rop, rarg, rhalt, 1'($urandom_range(0, 1)), "random");
      end

      issue(RUN, 32'd0);
      repeat (3) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      model_cc = 32'd0;
      check("midrun_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
      check("midrun_rst_done", {31'd0, done}, 32'd0);
      check("midrun_rst_cause", {30'd0, halt_cause}, 32'd0);
      check("midrun_rst_count", cycle_count, 32'd0);
      check("midrun_rst_halted", {31'd0, halted}, 32'd1);
      tick;
      check("midrun_rst_no_late_done", {31'd0, done}, 32'd0);
      exec(STEP, 32'd2, 0, 1'b0, "after_reset_step");

`ifdef DLX_BREAKPOINT_EN
      pc_load = 1'b1;
      tick;
      pc_load  = 1'b0;
      bp_addr  = 32'h40;
      bp_valid = 1'b1;
      issue(RUN, 32'd0);
      wait_stop(0, 1'b0, en_cnt, done_cnt, first_en);
      model_cc = model_cc + 32'd4;
      check("bp_en_cycles", 32'(en_cnt), 32'd4);
      check("bp_done", 32'(done_cnt), 32'd1);
      check("bp_cause", {30'd0, halt_cause}, 32'd3);
      check("bp_pc_held", pc, 32'h40);
      check("bp_cycle_count", cycle_count, model_cc);
      tick;
      exec(RUN, 32'd0, 3, 1'b0, "bp_resume");
      check("bp_resume_pc", pc, 32'h4c);
      bp_valid = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
